// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by alu_issue and its alu.
//   ALU_SUB .. ALU_SRA : 3-bit function codes
//   state_t            : issue FSM state encoding
//   is_shift()         : true for the shift codes (srl, sll, sra)
package alu_pkg;

    localparam logic [2:0] ALU_SUB = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] f);
        return (f == ALU_SRL) || (f == ALU_SLL) || (f == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   a_i, b_i : operands (b_i arrives pre-masked to the shift range for shifts)
//   f_i      : function code (alu_pkg::ALU_*)
//   y_o      : result, add/sub wrap around
//   t_o      : {ltu, lt, eq} for ALU_SUB, zero for every other code
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       f_i,
    output logic [WIDTH-1:0] y_o,
    output logic [2:0]       t_o
);

    always_comb begin
        y_o = '0;
        unique case (f_i)
            ALU_SUB: y_o = a_i - b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_SRL: y_o = a_i >> b_i;
            ALU_SLL: y_o = a_i << b_i;
            ALU_SRA: y_o = $unsigned($signed(a_i) >>> b_i);
            default: y_o = '0;
        endcase
    end

    always_comb begin
        t_o = 3'b000;
        if (f_i == ALU_SUB) begin
            t_o[2] = (a_i < b_i);
            t_o[1] = ($signed(a_i) < $signed(b_i));
            t_o[0] = (a_i == b_i);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: valid/ready wrapper issuing one command at a time to the alu,
// presenting the registered result until the consumer takes it.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : command handshake
//   in_a, in_b, in_f    : operands and function code
//   in_chain            : use last consumed result as operand a
//   out_valid/out_ready : result handshake
//   out_y, out_t        : registered result and {ltu, lt, eq} flags
//   op_cnt              : number of results consumed (wraps)
// Build option: define ALU_ISSUE_CHAIN_EN to enable the in_chain path;
// without it in_chain is ignored and no chain mux exists.
//
// state | meaning
// IDLE  | empty, ready for a command
// EXEC  | operands registered, alu result captured at the next edge
// HOLD  | result presented, waiting for out_ready
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_f,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_t,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2:0]         f_r;
    logic [WIDTH-1:0]   out_y_q;
    logic [2:0]         out_t_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   op_cnt_q;
    logic [WIDTH-1:0]   last_y_q, last_y_d;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_alu;
    logic [WIDTH-1:0]   alu_y;
    logic [2:0]         alu_t;
    logic               accept, retire;

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid_q && out_ready;

    // A chained command accepted in the same cycle as a retire must see
    // the result being retired, so chain from the next-state value.
    assign last_y_d = retire ? out_y_q : last_y_q;

`ifdef ALU_ISSUE_CHAIN_EN
    assign a_d = in_chain ? last_y_d : in_a;
`else
    logic unused_chain;
    assign unused_chain = in_chain;
    assign a_d = in_a;
`endif

    // Shift amounts are taken modulo WIDTH by keeping only the low bits.
    always_comb begin
        b_alu = b_r;
        if (is_shift(f_r))
            b_alu = {{(WIDTH-SHW){1'b0}}, b_r[SHW-1:0]};
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i (a_r),
        .b_i (b_alu),
        .f_i (f_r),
        .y_o (alu_y),
        .t_o (alu_t)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            f_r         <= '0;
            out_y_q     <= '0;
            out_t_q     <= '0;
            out_valid_q <= 1'b0;
            op_cnt_q    <= '0;
            last_y_q    <= '0;
        end else begin
            last_y_q <= last_y_d;
            if (retire)
                op_cnt_q <= op_cnt_q + CNT_W'(1);
            if (accept) begin
                a_r <= a_d;
                b_r <= in_b;
                f_r <= in_f;
            end
            case (state_q)
                IDLE: begin
                    if (accept)
                        state_q <= EXEC;
                end
                EXEC: begin
                    out_y_q     <= alu_y;
                    out_t_q     <= alu_t;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= in_valid ? EXEC : IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_t     = out_t_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_alu_issue;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_chain = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_f = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_y;
    logic [2:0]    out_t;
    logic [CW-1:0] op_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_f      (in_f),
        .in_chain  (in_chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_t     (out_t),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] f);
        int unsigned sh;
        logic [W-1:0] r;
        sh = b % W;
        case (f)
            3'd0: r = a - b;
            3'd1: r = a + b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a >> sh;
            3'd6: r = a << sh;
            default: begin
                r = a >> sh;
                if (a[W-1]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
        endcase
        return r;
    endfunction

    function automatic logic [2:0] ref_t(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] f);
        int sa, sb;
        if (f != 3'd0) return 3'b000;
        sa = $signed(a);
        sb = $signed(b);
        return {a < b, sa < sb, a == b};
    endfunction

    typedef struct {
        logic [W-1:0] y;
        logic [2:0]   t;
        int           vcyc;
    } res_t;

    res_t         mq[$];
    int           cyc = 0;
    int unsigned  m_cnt = 0;
    logic [W-1:0] m_last = '0;

    always @(negedge clk) begin : model
        logic ev, exp_rdy, acc, ret;
        logic [W-1:0] ea;
        res_t r;
        cyc++;
        if (rst) begin
            chk("rst out_valid", 32'(out_valid), 0);
            chk("rst in_ready", 32'(in_ready), 1);
            chk("rst op_cnt", 32'(op_cnt), 0);
            chk("rst out_y", out_y, 0);
            chk("rst out_t", 32'(out_t), 0);
            mq.delete();
            m_cnt  = 0;
            m_last = '0;
        end else begin
            ev      = (mq.size() > 0) && (cyc >= mq[0].vcyc);
            exp_rdy = (mq.size() == 0) || (ev && out_ready);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("op_cnt", 32'(op_cnt), m_cnt & 32'hFFFF);
            if (ev) begin
                chk("out_y", out_y, mq[0].y);
                chk("out_t", 32'(out_t), 32'(mq[0].t));
            end
            ret = ev && out_ready;
            acc = in_valid && exp_rdy;
            if (ret) begin
                m_last = mq[0].y;
                void'(mq.pop_front());
                m_cnt++;
            end
            if (acc) begin
                ea = in_a;
`ifdef ALU_ISSUE_CHAIN_EN
                if (in_chain) ea = m_last;
`endif
                r.y    = ref_y(ea, in_b, in_f);
                r.t    = ref_t(ea, in_b, in_f);
                r.vcyc = cyc + 2;
                mq.push_back(r);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input logic ch);
        bit got;
        got = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_f     = f;
        in_chain = ch;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_chain = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send timeout: in_ready never seen, expected 1");
        end
    endtask

    task automatic expect_result(input string nm, input logic [W-1:0] y, input logic [2:0] t,
                                 output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                lat = n;
                chk({nm, " y"}, out_y, y);
                chk({nm, " t"}, 32'(out_t), 32'(t));
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid never seen, expected 1", nm);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lat;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        send(32'd5, 32'd5, 3'd0, 1'b0);
        expect_result("sub eq", 32'd0, 3'b001, lat);
        chk("latency", lat, 1);

        send(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
        expect_result("signed cmp", 32'hFFFF_FFFE, 3'b010, lat);

        send(32'h8000_0000, 32'd33, 3'd7, 1'b0);
        expect_result("sra mask", 32'hC000_0000, 3'b000, lat);

        // backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'd7, 32'd8, 3'd1, 1'b0);
        expect_result("bp add", 32'd15, 3'b000, lat);
        repeat (5) begin
            @(negedge clk);
            chk("bp hold y", out_y, 32'd15);
            chk("bp in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd2;
        in_b      = 32'd3;
        in_f      = 3'd2;
        in_chain  = 1'b0;
        @(negedge clk);
        chk("bp accept ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp op_cnt", 32'(op_cnt), 4);
        expect_result("bp next", 32'd2, 3'b000, lat);

        // chaining
        send(32'd3, 32'd4, 3'd1, 1'b0);
        expect_result("chain first", 32'd7, 3'b000, lat);
        send(32'd100, 32'd10, 3'd1, 1'b1);
`ifdef ALU_ISSUE_CHAIN_EN
        expect_result("chain second", 32'd17, 3'b000, lat);
`else
        expect_result("chain second", 32'd110, 3'b000, lat);
`endif

        // reset while in EXEC
        send(32'd1, 32'd2, 3'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst out_valid", 32'(out_valid), 0);
        chk("mid rst in_ready", 32'(in_ready), 1);
        chk("mid rst op_cnt", 32'(op_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post rst no valid", 32'(out_valid), 0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 6);
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 70);
            if ($urandom_range(0, 7) == 0) in_b = in_a;
            in_f      = 3'($urandom_range(0, 7));
            in_chain  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
